// File: rtl/mem_store_unit_pkg.sv
// Shared store-path definitions: store-size codes, FSM states and the alignment rule.
package mem_store_unit_pkg;

  localparam logic [1:0] STORE_RSVD = 2'b00;
  localparam logic [1:0] STORE_BYTE = 2'b01;
  localparam logic [1:0] STORE_HALF = 2'b10;
  localparam logic [1:0] STORE_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_MERGE = 2'b10,
    ST_WRITE = 2'b11
  } store_state_t;

  // High when a request can never be performed: reserved size or misaligned half/word.
  function automatic logic store_reject(input logic [1:0] size, input logic [1:0] offset);
    logic rej;
    rej = 1'b0;
    case (size)
      STORE_RSVD: rej = 1'b1;
      STORE_HALF: rej = offset[0];
      STORE_WORD: rej = (offset != 2'b00);
      default:    rej = 1'b0;
    endcase
    return rej;
  endfunction

endpackage

// File: rtl/mem_store_unit_merge.sv
// store_merge: replaces the addressed byte/half lanes of an old memory word with new store data.
module store_merge
  import mem_store_unit_pkg::*;
#(
  parameter int NB_BITS = 32
) (
  input  logic [NB_BITS-1:0] old_word,
  input  logic [NB_BITS-1:0] data,
  input  logic [1:0]         size,
  input  logic [1:0]         offset,
  output logic [NB_BITS-1:0] merged
);

  always_comb begin
    merged = old_word;
    case (size)
      STORE_BYTE: begin
        case (offset)
          2'd0:    merged[7:0]   = data[7:0];
          2'd1:    merged[15:8]  = data[7:0];
          2'd2:    merged[23:16] = data[7:0];
          default: merged[31:24] = data[7:0];
        endcase
      end
      STORE_HALF: begin
        if (offset[1]) merged[31:16] = data[15:0];
        else           merged[15:0]  = data[15:0];
      end
      STORE_WORD: merged = data;
      default:    merged = old_word;
    endcase
  end

endmodule

// File: rtl/mem_store_unit.sv
// Store unit for a word-wide data memory without byte enables: SW writes directly,
// SB/SH go through read-merge-write. o_ready stalls the pipeline while busy.
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int NB_BITS = 32,
  parameter int NB_ADDR = 10
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic [NB_ADDR+1:0]   i_addr,
  input  logic [NB_BITS-1:0]   i_data,
  input  logic [1:0]           i_size,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_error,
  output logic [NB_ADDR-1:0]   o_mem_addr,
  output logic [NB_BITS-1:0]   o_mem_wdata,
  output logic                 o_mem_we,
  output logic                 o_mem_re,
  input  logic [NB_BITS-1:0]   i_mem_rdata
);

  store_state_t       state;
  logic [1:0]         offset_p0;
  logic [1:0]         size_p0;
  logic [NB_BITS-1:0] data_p0;
  logic [NB_BITS-1:0] merged;
  logic               accept;

  assign o_ready = (state == ST_IDLE);
  assign accept  = i_valid && o_ready;

  // Request capture: only consumed by the merge, so it needs no reset.
  always_ff @(posedge i_clock) begin
    if (accept) begin
      offset_p0 <= i_addr[1:0];
      size_p0   <= i_size;
      data_p0   <= i_data;
    end
  end

  store_merge #(.NB_BITS(NB_BITS)) u_merge (
    .old_word (i_mem_rdata),
    .data     (data_p0),
    .size     (size_p0),
    .offset   (offset_p0),
    .merged   (merged)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      o_done      <= 1'b0;
      o_error     <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_done   <= 1'b0;
      o_error  <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_re <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (store_reject(i_size, i_addr[1:0])) begin
              o_error <= 1'b1;
            end else if (i_size == STORE_WORD) begin
              o_mem_addr  <= i_addr[NB_ADDR+1:2];
              o_mem_wdata <= i_data;
              o_mem_we    <= 1'b1;
              o_done      <= 1'b1;
              state       <= ST_WRITE;
            end else begin
              o_mem_addr <= i_addr[NB_ADDR+1:2];
              o_mem_re   <= 1'b1;
              state      <= ST_READ;
            end
          end
        end
        ST_READ:  state <= ST_MERGE;
        // Read data arrives this cycle; the merged word is written next cycle.
        ST_MERGE: begin
          o_mem_wdata <= merged;
          o_mem_we    <= 1'b1;
          o_done      <= 1'b1;
          state       <= ST_WRITE;
        end
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit with a 1-cycle synchronous word memory model.
module tb_mem_store_unit;
  import mem_store_unit_pkg::*;

  localparam int NB_BITS = 32;
  localparam int NB_ADDR = 10;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_valid;
  logic [NB_ADDR+1:0] i_addr;
  logic [NB_BITS-1:0] i_data;
  logic [1:0]         i_size;
  logic               o_ready, o_done, o_error, o_mem_we, o_mem_re;
  logic [NB_ADDR-1:0] o_mem_addr;
  logic [NB_BITS-1:0] o_mem_wdata;
  logic [NB_BITS-1:0] mem_rdata;

  logic [NB_BITS-1:0] mem [0:(1<<NB_ADDR)-1];
  logic               pl_en = 1'b0;
  logic [NB_ADDR-1:0] pl_addr = '0;
  logic [NB_BITS-1:0] pl_data = '0;
  int                 we_cnt = 0;
  int                 both_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_store_unit #(.NB_BITS(NB_BITS), .NB_ADDR(NB_ADDR)) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_valid     (i_valid),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_size      (i_size),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_we    (o_mem_we),
    .o_mem_re    (o_mem_re),
    .i_mem_rdata (mem_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    if (o_mem_re) mem_rdata <= mem[o_mem_addr];
    if (o_mem_we) we_cnt++;
    if ((o_mem_we && o_mem_re) || (o_done && o_error)) both_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [NB_ADDR-1:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    step();
    pl_en   = 1'b0;
  endtask

  // Presents a request, waits (bounded) for o_ready, and returns one cycle after the accept edge.
  task automatic issue(input logic [NB_ADDR+1:0] a, input logic [31:0] d, input logic [1:0] sz,
                       output int waited);
    i_addr  = a;
    i_data  = d;
    i_size  = sz;
    i_valid = 1'b1;
    waited  = 0;
    while (!o_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!o_ready) check_val("ready_timeout", 32'(o_ready), 32'd1);
    step();
    i_valid = 1'b0;
  endtask

  initial begin
    int w;
    int we_before;
    i_valid = 1'b0;
    i_addr  = '0;
    i_data  = '0;
    i_size  = STORE_RSVD;
    rst_n   = 1'b0;
    #12;
    check_val("rst_ready", 32'(o_ready), 32'd1);
    check_val("rst_we", 32'(o_mem_we), 32'd0);
    check_val("rst_re", 32'(o_mem_re), 32'd0);
    check_val("rst_done_err", {30'd0, o_done, o_error}, 32'd0);
    check_val("rst_addr", 32'(o_mem_addr), 32'd0);
    check_val("rst_wdata", o_mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // SW to word 4
    issue(12'h010, 32'hDEADBEEF, STORE_WORD, w);
    check_val("sw_we", 32'(o_mem_we), 32'd1);
    check_val("sw_re", 32'(o_mem_re), 32'd0);
    check_val("sw_addr", 32'(o_mem_addr), 32'd4);
    check_val("sw_wdata", o_mem_wdata, 32'hDEADBEEF);
    check_val("sw_done", 32'(o_done), 32'd1);
    check_val("sw_busy", 32'(o_ready), 32'd0);
    step();
    check_val("sw_ready_back", 32'(o_ready), 32'd1);
    check_val("sw_we_off", 32'(o_mem_we), 32'd0);
    check_val("sw_mem", mem[4], 32'hDEADBEEF);

    // SB into byte lane 2 of word 1
    preload(10'd1, 32'h11223344);
    issue(12'h006, 32'h000000AA, STORE_BYTE, w);
    check_val("sb_re", 32'(o_mem_re), 32'd1);
    check_val("sb_we_n1", 32'(o_mem_we), 32'd0);
    check_val("sb_addr", 32'(o_mem_addr), 32'd1);
    step();
    check_val("sb_merge_idle", {30'd0, o_mem_we, o_mem_re}, 32'd0);
    step();
    check_val("sb_we", 32'(o_mem_we), 32'd1);
    check_val("sb_wdata", o_mem_wdata, 32'h11AA3344);
    check_val("sb_done", 32'(o_done), 32'd1);
    step();
    check_val("sb_ready_back", 32'(o_ready), 32'd1);
    check_val("sb_mem", mem[1], 32'h11AA3344);

    // SH into upper half of word 2
    preload(10'd2, 32'hCAFEBABE);
    issue(12'h00A, 32'h00001234, STORE_HALF, w);
    check_val("sh_busy1", 32'(o_ready), 32'd0);
    step();
    check_val("sh_busy2", 32'(o_ready), 32'd0);
    step();
    check_val("sh_busy3", 32'(o_ready), 32'd0);
    check_val("sh_wdata", o_mem_wdata, 32'h1234BABE);
    check_val("sh_addr", 32'(o_mem_addr), 32'd2);
    step();
    check_val("sh_ready_back", 32'(o_ready), 32'd1);
    check_val("sh_mem", mem[2], 32'h1234BABE);

    // SH into lower half of word 3
    preload(10'd3, 32'hCAFEBABE);
    issue(12'h00C, 32'hFFFF5678, STORE_HALF, w);
    step(); step(); step();
    check_val("sh_lo_mem", mem[3], 32'hCAFE5678);

    // Rejected requests: misaligned SH, misaligned SW, reserved size
    we_before = we_cnt;
    issue(12'h003, 32'h0000FFFF, STORE_HALF, w);
    check_val("sh_mis_err", 32'(o_error), 32'd1);
    check_val("sh_mis_mem", {30'd0, o_mem_we, o_mem_re}, 32'd0);
    check_val("sh_mis_ready", 32'(o_ready), 32'd1);
    check_val("sh_mis_done", 32'(o_done), 32'd0);
    step();
    check_val("sh_mis_err_pulse", 32'(o_error), 32'd0);
    issue(12'h002, 32'h12345678, STORE_WORD, w);
    check_val("sw_mis_err", 32'(o_error), 32'd1);
    check_val("sw_mis_mem", {30'd0, o_mem_we, o_mem_re}, 32'd0);
    check_val("sw_mis_ready", 32'(o_ready), 32'd1);
    step();
    check_val("sw_mis_err_pulse", 32'(o_error), 32'd0);
    issue(12'h020, 32'h12345678, STORE_RSVD, w);
    check_val("rsvd_err", 32'(o_error), 32'd1);
    step();
    check_val("reject_no_write", 32'(we_cnt - we_before), 32'd0);
    check_val("sw_mis_mem_word0", mem[0] === 32'h12345678 ? 32'd1 : 32'd0, 32'd0);

    // Reset during MERGE of an SB
    preload(10'd5, 32'hA5A5A5A5);
    we_before = we_cnt;
    issue(12'h014, 32'h000000FF, STORE_BYTE, w);
    step();
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_we", 32'(o_mem_we), 32'd0);
    check_val("rst_mid_ready", 32'(o_ready), 32'd1);
    check_val("rst_mid_addr", 32'(o_mem_addr), 32'd0);
    check_val("rst_mid_wdata", o_mem_wdata, 32'd0);
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    step(); step();
    check_val("rst_mid_no_write", 32'(we_cnt - we_before), 32'd0);
    check_val("rst_mid_mem", mem[5], 32'hA5A5A5A5);
    check_val("rst_after_ready", 32'(o_ready), 32'd1);
    issue(12'h014, 32'h0BADF00D, STORE_WORD, w);
    check_val("rst_after_sw_done", 32'(o_done), 32'd1);
    step();
    check_val("rst_after_sw_mem", mem[5], 32'h0BADF00D);

    // Back-to-back byte stores to word 0
    preload(10'd0, 32'h00000000);
    issue(12'h000, 32'h00000055, STORE_BYTE, w);
    check_val("b2b_first_nowait", 32'(w), 32'd0);
    issue(12'h001, 32'h00000066, STORE_BYTE, w);
    check_val("b2b_second_wait", 32'(w), 32'd3);
    check_val("b2b_second_re", 32'(o_mem_re), 32'd1);
    step(); step(); step();
    check_val("b2b_mem", mem[0], 32'h00006655);

    check_val("never_we_re_or_done_err", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
